// File: rtl/accum_pkg.sv
// Shared parameters, geometry helpers and FSM encoding for the
// accumulator drain engine.
package accum_pkg;

    localparam int DATA_WIDTH_DEF   = 8;
    localparam int SYS_ARR_COLS_DEF = 16;
    localparam int MAX_OUT_ROWS_DEF = 128;
    localparam int MAX_OUT_COLS_DEF = 128;

    function automatic int num_accum_rows(
        input int rows,
        input int cols,
        input int sa_cols
    );
        return rows * (cols / sa_cols);
    endfunction

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_ACCUM_ROWS_DEF = num_accum_rows(
        MAX_OUT_ROWS_DEF, MAX_OUT_COLS_DEF, SYS_ARR_COLS_DEF);
    localparam int ADDR_W_DEF = addr_width(NUM_ACCUM_ROWS_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/accum_drain_if.sv
// Row output stream of the drain engine (valid/ready).
interface accum_drain_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int SYS_ARR_COLS = 16
) ();

    logic                               out_valid;
    logic                               out_ready;
    logic [DATA_WIDTH*SYS_ARR_COLS-1:0] out_data;
    logic                               out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/accum_drain_fifo.sv
// 2-entry fall-through FIFO: an empty FIFO presents its input
// directly so a returning row can leave in the cycle it arrives.
module accum_drain_fifo #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         head_q, head_d;
    logic         tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop;

    always_comb begin
        out_valid = (cnt_q != 2'd0) || in_valid;
        out_data  = (cnt_q == 2'd0) ? in_data : mem_q[head_q];
        pop       = out_valid && out_ready;
        mem_d     = mem_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (in_valid) begin
            mem_d[tail_q] = in_data;
            tail_d        = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        cnt_d = cnt_q + {1'b0, in_valid} - {1'b0, pop};
    end

    assign count = cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/accum_drain.sv
// Drains a range of accumulator rows (all columns in parallel) onto a
// valid/ready stream, optionally clearing the table afterwards.
module accum_drain
    import accum_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int SYS_ARR_COLS = SYS_ARR_COLS_DEF,
    parameter int MAX_OUT_ROWS = MAX_OUT_ROWS_DEF,
    parameter int MAX_OUT_COLS = MAX_OUT_COLS_DEF,
    localparam int NUM_ACCUM_ROWS = num_accum_rows(
        MAX_OUT_ROWS, MAX_OUT_COLS, SYS_ARR_COLS),
    localparam int ADDR_W = addr_width(NUM_ACCUM_ROWS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [ADDR_W-1:0]                  base_addr,
    input  logic [ADDR_W:0]                    num_rows,
    input  logic                               clear_after,
    output logic                               busy,
    output logic                               done,
    output logic [SYS_ARR_COLS-1:0]            tbl_rd_en,
    output logic [ADDR_W*SYS_ARR_COLS-1:0]     tbl_rd_addr,
    input  logic [DATA_WIDTH*SYS_ARR_COLS-1:0] tbl_rd_data,
    output logic [SYS_ARR_COLS-1:0]            tbl_reset,
    accum_drain_if.master                      out
);

    localparam int RW = DATA_WIDTH * SYS_ARR_COLS;
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(NUM_ACCUM_ROWS - 1);
    localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   N_ONE    = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     nrows_q, nrows_d;
    logic [ADDR_W:0]     iss_q, iss_d;
    logic                clr_q, clr_d;
    logic                pend_q, pend_d;
    logic                lastp_q, lastp_d;
    logic                done_q, done_d;

    logic                rd_en;
    logic                f_valid;
    logic [RW:0]         f_data;
    logic [1:0]          f_cnt;
    logic [2:0]          occ;
    logic                last_xfer;

    assign occ       = {1'b0, f_cnt} + {2'b00, pend_q};
    assign last_xfer = f_valid && out.out_ready && f_data[RW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && num_rows != '0) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_xfer) state_d = clr_q ? ST_CLEAR : ST_IDLE;
            end
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q != ST_IDLE;
        tbl_reset = {SYS_ARR_COLS{state_q == ST_CLEAR}};
        // Issue only when the FIFO can absorb every outstanding row.
        rd_en     = (state_q == ST_DRAIN) && (iss_q != nrows_q)
                    && (occ < 3'd2);
    end

    always_comb begin
        addr_d  = addr_q;
        nrows_d = nrows_q;
        clr_d   = clr_q;
        iss_d   = iss_q;
        pend_d  = rd_en;
        lastp_d = rd_en && (iss_q == nrows_q - N_ONE);
        done_d  = (state_q != ST_IDLE) && (state_d == ST_IDLE);
        if (state_q == ST_IDLE && start) begin
            addr_d  = base_addr;
            nrows_d = num_rows;
            clr_d   = clear_after;
            iss_d   = '0;
            done_d  = num_rows == '0;
        end
        if (rd_en) begin
            addr_d = (addr_q == ADDR_MAX) ? '0 : addr_q + A_ONE;
            iss_d  = iss_q + N_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            nrows_q <= '0;
            clr_q   <= 1'b0;
            iss_q   <= '0;
            pend_q  <= 1'b0;
            lastp_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            nrows_q <= nrows_d;
            clr_q   <= clr_d;
            iss_q   <= iss_d;
            pend_q  <= pend_d;
            lastp_q <= lastp_d;
            done_q  <= done_d;
        end
    end

    accum_drain_fifo #(
        .W(RW + 1)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .in_valid (pend_q),
        .in_data  ({lastp_q, tbl_rd_data}),
        .out_ready(out.out_ready),
        .out_valid(f_valid),
        .out_data (f_data),
        .count    (f_cnt)
    );

    assign done          = done_q;
    assign tbl_rd_en     = {SYS_ARR_COLS{rd_en}};
    assign tbl_rd_addr   = rd_en ? {SYS_ARR_COLS{addr_q}} : '0;
    assign out.out_valid = f_valid;
    assign out.out_data  = f_valid ? f_data[RW-1:0] : '0;
    assign out.out_last  = f_valid && f_data[RW];

endmodule

// File: tb/tb_accum_drain.sv
// Directed bench for accum_drain on a 16-row, 4-column table with
// a one-cycle-latency table model.
module tb_accum_drain;

    localparam int DW  = 8;
    localparam int SAC = 4;
    localparam int AW  = 4;
    localparam int NR  = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [AW-1:0]      base_addr = '0;
    logic [AW:0]        num_rows = '0;
    logic               clear_after = 1'b0;
    logic               busy, done;
    logic [SAC-1:0]     tbl_rd_en;
    logic [AW*SAC-1:0]  tbl_rd_addr;
    logic [DW*SAC-1:0]  tbl_rd_data = '0;
    logic [SAC-1:0]     tbl_reset;

    accum_drain_if #(.DATA_WIDTH(DW), .SYS_ARR_COLS(SAC)) oif ();

    accum_drain #(
        .DATA_WIDTH  (DW),
        .SYS_ARR_COLS(SAC),
        .MAX_OUT_ROWS(8),
        .MAX_OUT_COLS(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .clear_after(clear_after),
        .busy       (busy),
        .done       (done),
        .tbl_rd_en  (tbl_rd_en),
        .tbl_rd_addr(tbl_rd_addr),
        .tbl_rd_data(tbl_rd_data),
        .tbl_reset  (tbl_reset),
        .out        (oif)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] rowv(input logic [3:0] a);
        return {4'hC, a, 4'h8, a, 4'h4, a, 4'h0, a};
    endfunction

    always @(posedge clk) begin
        if (tbl_rd_en[0]) tbl_rd_data <= rowv(tbl_rd_addr[AW-1:0]);
    end

    logic [AW*SAC-1:0] rd_q[$];
    int                rd_cyc_q[$];
    logic [31:0]       xd_q[$];
    logic              xl_q[$];
    int                xc_q[$];
    int done_cnt = 0, done_cyc = 0;
    int tr_cnt = 0, tr_cyc = 0, busy_cnt = 0;
    logic [SAC-1:0] tr_val = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        logic        st_prev;
        logic [31:0] st_data;
        logic        st_last;
        st_prev = 1'b0;
        st_data = '0;
        st_last = 1'b0;
        forever begin
            @(negedge clk);
            if (st_prev && reset) begin
                chk("stall_valid", oif.out_valid, 1);
                chk("stall_data", oif.out_data, st_data);
                chk("stall_last", oif.out_last, st_last);
            end
            st_prev = reset && oif.out_valid && !oif.out_ready;
            st_data = oif.out_data;
            st_last = oif.out_last;
            if (tbl_rd_en != '0) begin
                chk("rd_en_all", tbl_rd_en, 4'hF);
                rd_q.push_back(tbl_rd_addr);
                rd_cyc_q.push_back(cyc);
            end
            if (oif.out_valid && oif.out_ready) begin
                xd_q.push_back(oif.out_data);
                xl_q.push_back(oif.out_last);
                xc_q.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (tbl_reset != '0) begin
                tr_cnt++;
                tr_cyc = cyc;
                tr_val = tbl_reset;
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic run(input int base, input int n, input bit clr,
                       input int mode, input bit restart);
        int rd0, xf0, dn0, tr0, bz0, s, j, nr, nx, lx;
        logic [3:0] ea;
        rd0 = rd_q.size();
        xf0 = xd_q.size();
        dn0 = done_cnt;
        tr0 = tr_cnt;
        bz0 = busy_cnt;
        @(posedge clk); #1;
        base_addr   = base[3:0];
        num_rows    = n[4:0];
        clear_after = clr;
        start       = 1'b1;
        oif.out_ready = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start       = 1'b0;
        base_addr   = 4'hF;
        num_rows    = '0;
        clear_after = 1'b0;
        j = 0;
        while (j < 100 && done_cnt == dn0) begin
            oif.out_ready = (mode == 0) ? 1'b1 : (j % 2 == 0);
            if (restart && j == 0) begin
                start     = 1'b1;
                base_addr = 4'd5;
                num_rows  = 5'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            j++;
        end
        start = 1'b0;
        oif.out_ready = 1'b1;
        if (done_cnt == dn0) chk("timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
        nr = rd_q.size() - rd0;
        nx = xd_q.size() - xf0;
        chk("n_reads", nr, n);
        chk("n_rows_out", nx, n);
        chk("n_done", done_cnt - dn0, 1);
        for (int i = 0; i < n && i < nr; i++) begin
            ea = 4'((base + i) % NR);
            chk("rd_addr", rd_q[rd0+i], {4{ea}});
            if (mode == 0) chk("rd_cycle", rd_cyc_q[rd0+i], s + 1 + i);
        end
        for (int i = 0; i < n && i < nx; i++) begin
            ea = 4'((base + i) % NR);
            chk("out_data", xd_q[xf0+i], rowv(ea));
            chk("out_last", xl_q[xf0+i], i == n - 1);
        end
        if (n == 0) begin
            chk("zero_done_cyc", done_cyc, s + 1);
        end else if (nx > 0) begin
            lx = xc_q[xf0+nx-1];
            if (mode == 0) chk("first_out_cyc", xc_q[xf0], s + 2);
            if (clr) begin
                chk("treset_cyc", tr_cyc, lx + 1);
                chk("treset_val", tr_val, 4'hF);
                chk("done_cyc", done_cyc, tr_cyc + 1);
            end else begin
                chk("done_cyc", done_cyc, lx + 1);
            end
        end
        chk("n_treset", tr_cnt - tr0, clr && n > 0);
        if (mode == 0)
            chk("busy_cycles", busy_cnt - bz0, (n == 0) ? 0 : n + 1 + clr);
    endtask

    initial begin
        int dn0, tr0;
        oif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", oif.out_valid, 0);
        chk("rst_rd_en", tbl_rd_en, 0);
        chk("rst_treset", tbl_reset, 0);
        reset = 1'b1;

        run(0, 4, 0, 0, 0);
        run(NR - 2, 4, 0, 0, 0);
        run(2, 8, 0, 1, 0);
        run(6, 2, 1, 0, 0);
        run(10, 3, 1, 1, 0);
        run(0, 0, 0, 0, 0);
        run(0, 4, 0, 0, 1);

        @(posedge clk); #1;
        base_addr = 4'd3;
        num_rows  = 5'd16;
        start     = 1'b1;
        oif.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy_pre", busy, 1);
        dn0 = done_cnt;
        tr0 = tr_cnt;
        reset = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_valid", oif.out_valid, 0);
        chk("mid_last", oif.out_last, 0);
        chk("mid_data", oif.out_data, 0);
        chk("mid_rd_en", tbl_rd_en, 0);
        chk("mid_rd_addr", tbl_rd_addr, 0);
        chk("mid_treset", tbl_reset, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_no_done", done_cnt - dn0, 0);
        chk("mid_no_treset", tr_cnt - tr0, 0);
        chk("mid_idle", busy, 0);
        run(9, 4, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/accum_drain.md
ACCUM_DRAIN -- requirements
Module: accum_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per accumulator element.
REQ-002 SHALL have parameter SYS_ARR_COLS, default 16, columns read in parallel.
REQ-003 SHALL have parameters MAX_OUT_ROWS, default 128, and MAX_OUT_COLS, default 128; NUM_ACCUM_ROWS = MAX_OUT_ROWS*(MAX_OUT_COLS/SYS_ARR_COLS), ADDR_W = clog2(NUM_ACCUM_ROWS).
REQ-004 SHALL have: clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have: start  input  1  one-cycle drain request.
REQ-007 SHALL have: base_addr  input  ADDR_W  first row to drain; num_rows  input  ADDR_W+1  row count, 0..NUM_ACCUM_ROWS.
REQ-008 SHALL have: clear_after  input  1  clear table columns after drain.
REQ-009 SHALL have: busy  output  1  drain in progress; done  output  1  one-cycle completion pulse.
REQ-010 SHALL have: tbl_rd_en  output  SYS_ARR_COLS  per-column read enable; tbl_rd_addr  output  ADDR_W*SYS_ARR_COLS  per-column address.
REQ-011 SHALL have: tbl_rd_data  input  DATA_WIDTH*SYS_ARR_COLS  table read data; tbl_reset  output  SYS_ARR_COLS  per-column clear.
REQ-012 SHALL have: out_valid  output  1; out_ready  input  1; out_data  output  DATA_WIDTH*SYS_ARR_COLS; out_last  output  1  final row marker.

Function
REQ-013 SHALL implement states IDLE, DRAIN, CLEAR; IDLE->DRAIN on start with num_rows>0; DRAIN->CLEAR after last row accepted when clear_after latched; DRAIN->IDLE otherwise; CLEAR->IDLE after one cycle.
REQ-014 SHALL latch base_addr, num_rows, clear_after on accepted start; start while busy is ignored.
REQ-015 SHALL, on start with num_rows=0, pulse done next cycle, issue no reads, stay IDLE.
REQ-016 SHALL drive all tbl_rd_en bits identically and all tbl_rd_addr fields with the same row address.
REQ-017 SHALL treat table read latency as exactly 1 cycle: tbl_rd_data valid cycle after tbl_rd_en.
REQ-018 SHALL issue row i at address (base_addr+i) mod NUM_ACCUM_ROWS, i = 0..num_rows-1, in order.
REQ-019 SHALL buffer returned rows in a 2-entry FIFO; a read is issued only if FIFO occupancy plus in-flight reads < 2.
REQ-020 SHALL transfer a row when out_valid && out_ready; out_data, out_last stable while out_valid && !out_ready.
REQ-021 SHALL assert out_last only with the row num_rows-1.
REQ-022 SHALL achieve 1 row/cycle with out_ready held high; first tbl_rd_en cycle after start, first out_valid two cycles after start.
REQ-023 SHALL assert busy from cycle after start through final cycle of DRAIN/CLEAR; done pulses in cycle busy falls.
REQ-024 SHALL drive tbl_reset all-ones for exactly the one CLEAR cycle, zero otherwise.
REQ-025 SHALL never drop, duplicate, or reorder rows under arbitrary out_ready patterns.

Reset
REQ-026 SHALL, on reset low, asynchronously force IDLE, flush FIFO, clear counters, drive busy, done, out_valid, out_last, tbl_rd_en, tbl_reset, tbl_rd_addr, out_data to 0.
REQ-027 SHALL abandon a drain on mid-operation reset; no done pulse, no tbl_reset afterward.

Structure
REQ-028 SHALL place parameter defaults, ADDR_W/NUM_ACCUM_ROWS derivation, and the state encoding in shared package accum_pkg.
REQ-029 SHALL instantiate one sub-module accum_drain_fifo (2-entry, DATA_WIDTH*SYS_ARR_COLS+1 bits wide, valid/ready).

Verification
REQ-030 SHALL cover: base_addr=0, num_rows=4, out_ready=1 -> addresses 0,1,2,3 on consecutive cycles, 4 rows out, out_last on 4th, done once.
REQ-031 SHALL cover: base_addr=NUM_ACCUM_ROWS-2, num_rows=4 -> addresses NUM_ACCUM_ROWS-2, NUM_ACCUM_ROWS-1, 0, 1.
REQ-032 SHALL cover: num_rows=8, out_ready toggling 1010... -> 8 rows in order, data stable while stalled, no extra reads.
REQ-033 SHALL cover: num_rows=2, clear_after=1 -> tbl_reset=all-ones for one cycle after second transfer, then done.
REQ-034 SHALL cover: start with num_rows=0 -> done next cycle, tbl_rd_en never asserted; second start while busy ignored.
REQ-035 SHALL cover: reset low mid-drain of 16 rows -> all outputs 0 immediately, no done, new start drains correctly.
